// File: rtl/mac_rx_frame_fifo.sv
// mac_rx_frame_fifo: store-and-forward receive frame FIFO; frames are committed on a good eof
// and dropped on bad FCS, error, restart or overflow, then replayed with an inter-frame gap.
module mac_rx_frame_fifo #(
  parameter int ADDR_W = 11,
  parameter int IFG    = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  mac_rx_data,
  input  logic        mac_rx_valid,
  input  logic        mac_rx_sof,
  input  logic        mac_rx_eof,
  input  logic        mac_rx_fr_good,
  input  logic        mac_rx_fr_err,
  output logic [7:0]  mac_tx_data,
  output logic        mac_tx_valid,
  output logic        mac_tx_sof,
  output logic        mac_tx_eof,
  output logic [15:0] drop_cnt,
  output logic [15:0] fwd_cnt,
  output logic        ovf
);
  localparam logic [ADDR_W:0] DEPTH    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [7:0]      GAP_LOAD = 8'(IFG - 1);
  typedef enum logic [1:0] {W_IDLE, W_RECV, W_DISCARD} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_STREAM, R_GAP} rstate_t;
  wstate_t         ws_q, ws_d;
  rstate_t         rs_q, rs_d;
  logic [ADDR_W:0] wptr_q, wptr_d, cptr_q, cptr_d, rptr_q, rptr_d, waddr;
  logic [8:0]      mem [2**ADDR_W];
  logic [8:0]      rdata_q;
  logic            we, re, open, rx_sof, rx_eof, full_at, ovf_set, start, fwd_inc;
  logic            first_q, first_d;
  logic [1:0]      drops;
  logic [16:0]     drop_sum;
  logic [7:0]      gap_q, gap_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d, tx_sof_q, tx_sof_d, tx_eof_q, tx_eof_d;
  logic [15:0]     drop_cnt_q, fwd_cnt_q;
  logic            ovf_q;
  assign rx_sof   = mac_rx_valid & mac_rx_sof;
  assign rx_eof   = mac_rx_valid & mac_rx_eof;
  assign drop_sum = {1'b0, drop_cnt_q} + {15'd0, drops};
  // A new sof always restarts at the commit pointer, discarding whatever was open.
  always_comb begin
    ws_d    = ws_q;
    wptr_d  = wptr_q;
    cptr_d  = cptr_q;
    we      = 1'b0;
    ovf_set = 1'b0;
    drops   = (rx_sof && ws_q == W_RECV) ? 2'd1 : 2'd0;
    waddr   = rx_sof ? cptr_q : wptr_q;
    full_at = (waddr - rptr_q) == DEPTH;
    open    = rx_sof || ws_q == W_RECV;
    if (open && mac_rx_fr_err) begin
      drops  = drops + 2'd1;
      wptr_d = cptr_q;
      ws_d   = rx_eof ? W_IDLE : W_DISCARD;
    end else if (open && mac_rx_valid && full_at) begin
      drops   = drops + 2'd1;
      ovf_set = 1'b1;
      wptr_d  = cptr_q;
      ws_d    = rx_eof ? W_IDLE : W_DISCARD;
    end else if (open && mac_rx_valid) begin
      we     = 1'b1;
      wptr_d = waddr + 1'b1;
      ws_d   = rx_eof ? W_IDLE : W_RECV;
      if (rx_eof && mac_rx_fr_good) cptr_d = waddr + 1'b1;
      if (rx_eof && !mac_rx_fr_good) begin
        drops  = drops + 2'd1;
        wptr_d = cptr_q;
      end
    end else if (ws_q == W_DISCARD && rx_eof) begin
      ws_d = W_IDLE;
    end
  end
  // Reads run one beat ahead of the output register; the eof marker stops further reads.
  always_comb begin
    rs_d       = rs_q;
    rptr_d     = rptr_q;
    re         = 1'b0;
    first_d    = first_q;
    gap_d      = gap_q;
    fwd_inc    = 1'b0;
    tx_valid_d = 1'b0;
    tx_data_d  = 8'd0;
    tx_sof_d   = 1'b0;
    tx_eof_d   = 1'b0;
    start      = cptr_q != rptr_q && (rs_q == R_IDLE || (rs_q == R_GAP && gap_q == 8'd0));
    if (rs_q == R_STREAM) begin
      tx_valid_d = 1'b1;
      tx_data_d  = rdata_q[7:0];
      tx_sof_d   = first_q;
      tx_eof_d   = rdata_q[8];
      first_d    = 1'b0;
      rs_d       = rdata_q[8] ? R_GAP : R_STREAM;
      gap_d      = rdata_q[8] ? GAP_LOAD : gap_q;
      fwd_inc    = rdata_q[8];
      re         = !rdata_q[8];
      rptr_d     = rdata_q[8] ? rptr_q : rptr_q + 1'b1;
    end else if (start) begin
      re      = 1'b1;
      rptr_d  = rptr_q + 1'b1;
      first_d = 1'b1;
      rs_d    = R_STREAM;
    end else if (rs_q == R_GAP) begin
      rs_d  = (gap_q == 8'd0) ? R_IDLE : R_GAP;
      gap_d = (gap_q == 8'd0) ? gap_q : gap_q - 8'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ws_q       <= W_IDLE;
      rs_q       <= R_IDLE;
      wptr_q     <= '0;
      cptr_q     <= '0;
      rptr_q     <= '0;
      first_q    <= 1'b0;
      gap_q      <= 8'd0;
      tx_data_q  <= 8'd0;
      tx_valid_q <= 1'b0;
      tx_sof_q   <= 1'b0;
      tx_eof_q   <= 1'b0;
      drop_cnt_q <= 16'd0;
      fwd_cnt_q  <= 16'd0;
      ovf_q      <= 1'b0;
    end else begin
      ws_q       <= ws_d;
      rs_q       <= rs_d;
      wptr_q     <= wptr_d;
      cptr_q     <= cptr_d;
      rptr_q     <= rptr_d;
      first_q    <= first_d;
      gap_q      <= gap_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tx_sof_q   <= tx_sof_d;
      tx_eof_q   <= tx_eof_d;
      drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      fwd_cnt_q  <= fwd_cnt_q + {15'd0, fwd_inc};
      ovf_q      <= ovf_q | ovf_set;
    end
  end
  always_ff @(posedge clk) begin
    if (we) mem[waddr[ADDR_W-1:0]] <= {mac_rx_eof, mac_rx_data};
    if (re) rdata_q <= mem[rptr_q[ADDR_W-1:0]];
  end
  assign mac_tx_data  = tx_data_q;
  assign mac_tx_valid = tx_valid_q;
  assign mac_tx_sof   = tx_sof_q;
  assign mac_tx_eof   = tx_eof_q;
  assign drop_cnt     = drop_cnt_q;
  assign fwd_cnt      = fwd_cnt_q;
  assign ovf          = ovf_q;
endmodule
